mole_round_controller: RTL and testbench

MOLE_ROUND_CONTROLLER -- requirements
Module: mole_round_controller

---
 rtl/mole_round_controller.sv | 131 +++++++++++++
 tb/tb_mole_round_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: dark gap, then one lit box until a hit or timeout.
// All outputs are registered; the next values are computed in one combinational block.
module mole_round_controller #(
    parameter int GAP_CYCLES    = 5_000_000,
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int NUM_ROUNDS    = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] box_sel,
    input  logic [3:0] hit,
    output logic [2:0] active_box,
    output logic [3:0] led,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [4:0] round_num,
    output logic       game_over
);

    localparam int TMAX = (GAP_CYCLES > WINDOW_CYCLES) ? GAP_CYCLES : WINDOW_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] WIN_LAST   = TW'(WINDOW_CYCLES - 1);
    localparam logic [4:0]    LAST_ROUND = 5'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    hit_prev;
    logic [3:0]    hit_edge;
    logic          lit_edge, wrong_edge, round_end;
    logic [2:0]    active_box_n;
    logic [3:0]    led_n;
    logic [7:0]    score_n, misses_n;
    logic [4:0]    round_num_n;
    logic          game_over_n;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            hit_prev   <= '0;
            active_box <= '0;
            led        <= '0;
            score      <= '0;
            misses     <= '0;
            round_num  <= '0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            hit_prev   <= hit;
            active_box <= active_box_n;
            led        <= led_n;
            score      <= score_n;
            misses     <= misses_n;
            round_num  <= round_num_n;
            game_over  <= game_over_n;
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer + 1'b1;
        active_box_n = active_box;
        score_n      = score;
        misses_n     = misses;
        round_num_n  = round_num;
        game_over_n  = game_over;
        round_end    = 1'b0;

        // led is one-hot of the lit box, so it doubles as the lit-box mask
        hit_edge   = hit & ~hit_prev;
        lit_edge   = |(hit_edge & led);
        wrong_edge = |(hit_edge & ~led);

        case (state)
            IDLE, DONE: begin
                timer_n      = '0;
                active_box_n = '0;
                if (start) begin
                    score_n     = '0;
                    misses_n    = '0;
                    round_num_n = '0;
                    game_over_n = 1'b0;
                    state_n     = GAP;
                end
            end
            GAP: begin
                active_box_n = '0;
                if (timer == GAP_LAST) begin
                    timer_n      = '0;
                    round_num_n  = round_num + 5'd1;
                    active_box_n = (box_sel >= 3'd1 && box_sel <= 3'd4) ? box_sel : 3'd1;
                    state_n      = SHOW;
                end
            end
            SHOW: begin
                if (lit_edge) begin
                    round_end = 1'b1;
                    if (score != 8'hFF) score_n = score + 8'd1;
                end else if (wrong_edge || timer == WIN_LAST) begin
                    round_end = 1'b1;
                    if (misses != 8'hFF) misses_n = misses + 8'd1;
                end
                if (round_end) begin
                    timer_n      = '0;
                    active_box_n = '0;
                    if (round_num == LAST_ROUND) begin
                        game_over_n = 1'b1;
                        state_n     = DONE;
                    end else begin
                        state_n     = GAP;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        case (active_box_n)
            3'd1:    led_n = 4'b0001;
            3'd2:    led_n = 4'b0010;
            3'd3:    led_n = 4'b0100;
            3'd4:    led_n = 4'b1000;
            default: led_n = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_mole_round_controller.sv
// Directed bench for mole_round_controller with short gap/window and three rounds.
module tb_mole_round_controller;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] box_sel;
    logic [3:0] hit;
    logic [2:0] active_box;
    logic [3:0] led;
    logic [7:0] score;
    logic [7:0] misses;
    logic [4:0] round_num;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    mole_round_controller #(
        .GAP_CYCLES   (4),
        .WINDOW_CYCLES(8),
        .NUM_ROUNDS   (3)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .start     (start),
        .box_sel   (box_sel),
        .hit       (hit),
        .active_box(active_box),
        .led       (led),
        .score     (score),
        .misses    (misses),
        .round_num (round_num),
        .game_over (game_over)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ab, input logic [3:0] l,
                           input logic [7:0] s, input logic [7:0] m, input logic [4:0] r,
                           input logic go);
        chk({tag, ".active_box"}, 32'(active_box), 32'(ab));
        chk({tag, ".led"},        32'(led),        32'(l));
        chk({tag, ".score"},      32'(score),      32'(s));
        chk({tag, ".misses"},     32'(misses),     32'(m));
        chk({tag, ".round_num"},  32'(round_num),  32'(r));
        chk({tag, ".game_over"},  32'(game_over),  32'(go));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; box_sel = 3'd0; hit = 4'b0000;
        #35;
        chk_all("reset", 3'd0, 4'b0000, 8'd0, 8'd0, 5'd0, 1'b0);
        reset = 1'b0;
        step();
        chk_all("idle", 3'd0, 4'b0000, 8'd0, 8'd0, 5'd0, 1'b0);

        // Game 1, round 1: box 3, correct hit
        box_sel = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("g1r1.gap0.led", 32'(led), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("g1r1.gap.led", 32'(led), 32'd0);
        end
        step();
        chk_all("g1r1.show", 3'd3, 4'b0100, 8'd0, 8'd0, 5'd1, 1'b0);
        hit = 4'b0100;
        step();
        hit = 4'b0000;
        chk_all("g1r1.hit", 3'd0, 4'b0000, 8'd1, 8'd0, 5'd1, 1'b0);

        // Round 2: button held from gap into show must not score; timeout after 8 cycles
        box_sel = 3'd3;
        step();
        hit = 4'b0100;
        for (int i = 1; i < 4; i++) step();
        chk_all("g1r2.show", 3'd3, 4'b0100, 8'd1, 8'd0, 5'd2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("g1r2.held.active_box", 32'(active_box), 32'd3);
        end
        step();
        hit = 4'b0000;
        chk_all("g1r2.timeout", 3'd0, 4'b0000, 8'd1, 8'd1, 5'd2, 1'b0);

        // Round 3: box 2, lit and wrong bits rise together -> score only; game ends
        box_sel = 3'd2;
        for (int i = 0; i < 4; i++) step();
        chk_all("g1r3.show", 3'd2, 4'b0010, 8'd1, 8'd1, 5'd3, 1'b0);
        hit = 4'b0110;
        step();
        hit = 4'b0000;
        chk_all("g1r3.done", 3'd0, 4'b0000, 8'd2, 8'd1, 5'd3, 1'b1);
        step();
        step();
        chk_all("done.hold", 3'd0, 4'b0000, 8'd2, 8'd1, 5'd3, 1'b1);

        // Game 2 from DONE; box_sel 0 maps to box 1
        box_sel = 3'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk_all("g2.start", 3'd0, 4'b0000, 8'd0, 8'd0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk_all("g2r1.show", 3'd1, 4'b0001, 8'd0, 8'd0, 5'd1, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_all("g2r1.start_ignored", 3'd1, 4'b0001, 8'd0, 8'd0, 5'd1, 1'b0);
        hit = 4'b1000;
        step();
        hit = 4'b0000;
        chk_all("g2r1.wrong", 3'd0, 4'b0000, 8'd0, 8'd1, 5'd1, 1'b0);

        // Round 2: box_sel 6 maps to box 1, correct hit
        box_sel = 3'd6;
        for (int i = 0; i < 4; i++) step();
        chk_all("g2r2.show", 3'd1, 4'b0001, 8'd0, 8'd1, 5'd2, 1'b0);
        hit = 4'b0001;
        step();
        hit = 4'b0000;
        chk_all("g2r2.hit", 3'd0, 4'b0000, 8'd1, 8'd1, 5'd2, 1'b0);

        // Round 3: async reset between edges mid-show
        box_sel = 3'd4;
        for (int i = 0; i < 4; i++) step();
        chk_all("g2r3.show", 3'd4, 4'b1000, 8'd1, 8'd1, 5'd3, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 3'd0, 4'b0000, 8'd0, 8'd0, 5'd0, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk_all("post_reset_idle", 3'd0, 4'b0000, 8'd0, 8'd0, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
